hazard_scoreboard: RTL and testbench

Parametrised successor to the pipeline's data-hazard unit. It keeps its own shadow pipeline of in-flight register writers, from EX through the last forwarding stage. For each source operand of the instruction in ID, it produces a per-operand forwarding select and a combined stall. Load and ALU result latencies are configurable, and the number of source operands is configurable. It sits beside the ID/EX pipeline register and drives the EX-stage operand muxes and the PC/IF-ID write enables.

---
 rtl/hazard_scoreboard.sv | 92 +++++++++
 tb/tb_hazard_scoreboard.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard: shadow pipeline of in-flight writers, per-operand forwarding selects and a combined stall.
// Optional macro HAZARD_PERF_CNT_EN adds a saturating 32-bit stall-cycle counter (o_stall_cycles).
module hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int ALU_LAT    = 0,
  parameter int LOAD_LAT   = 1,
  parameter int ADDR_W     = 5,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_hold,
  input  logic                      i_flush,
  input  logic                      i_issue_regwrite,
  input  logic                      i_issue_memread,
  input  logic [ADDR_W-1:0]         i_issue_rd,
  input  logic [NUM_SRC*ADDR_W-1:0] i_src_addr,
  input  logic [NUM_SRC-1:0]        i_src_used,
  output logic [NUM_SRC*SEL_W-1:0]  o_fwd_sel,
  output logic                      o_stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               o_stall_cycles
`endif
);

  logic [FWD_STAGES-1:0]             ent_valid;
  logic [FWD_STAGES-1:0]             ent_memread;
  logic [FWD_STAGES-1:0][ADDR_W-1:0] ent_rd;

  logic [NUM_SRC-1:0] stall_req;
  logic [ADDR_W-1:0]  src;
  logic               hit;
  logic               hit_ld;
  logic [SEL_W-1:0]   hit_k;
  logic [SEL_W-1:0]   ready;

  always_comb begin
    o_fwd_sel = '0;
    stall_req = '0;
    src       = '0;
    hit       = 1'b0;
    hit_ld    = 1'b0;
    hit_k     = '0;
    ready     = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      src    = i_src_addr[j*ADDR_W +: ADDR_W];
      hit    = 1'b0;
      hit_ld = 1'b0;
      hit_k  = '0;
      // Youngest writer wins: once an entry matches, older ones are ignored.
      for (int unsigned k = 0; k < FWD_STAGES; k++) begin
        if (!hit && ent_valid[k] && (ent_rd[k] != '0) && (ent_rd[k] == src)) begin
          hit    = 1'b1;
          hit_ld = ent_memread[k];
          hit_k  = SEL_W'(k);
        end
      end
      ready = hit_ld ? SEL_W'(LOAD_LAT) : SEL_W'(ALU_LAT);
      if (i_src_used[j] && (src != '0) && hit) begin
        if (hit_k >= ready) o_fwd_sel[j*SEL_W +: SEL_W] = hit_k + SEL_W'(1);
        else                stall_req[j] = 1'b1;
      end
    end
  end

  assign o_stall = |stall_req;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ent_valid <= '0;
    end else if (!i_hold) begin
      for (int unsigned k = FWD_STAGES - 1; k > 0; k--) begin
        ent_valid[k]   <= ent_valid[k-1];
        ent_memread[k] <= ent_memread[k-1];
        ent_rd[k]      <= ent_rd[k-1];
      end
      ent_valid[0]   <= i_issue_regwrite && !o_stall && !i_flush;
      ent_memread[0] <= i_issue_memread;
      ent_rd[0]      <= i_issue_rd;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)                                         o_stall_cycles <= '0;
    else if (o_stall && !i_hold && (o_stall_cycles != '1)) o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: default DUT (2 stages, LOAD_LAT=1) and a 3-stage DUT with LOAD_LAT=2 driven in parallel.
// Expected values come from a queue-style shadow model evaluated from the forwarding/stall rules.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hold = 1'b0;
  logic       flush = 1'b0;
  logic       rw = 1'b0;
  logic       mr = 1'b0;
  logic [4:0] rd = '0;
  logic [9:0] src = '0;
  logic [1:0] used = '0;
  logic [3:0] sel2, sel3;
  logic       st2, st3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cyc2, cyc3;
  int unsigned cnt2 = 0, cnt3 = 0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_flush(flush),
    .i_issue_regwrite(rw), .i_issue_memread(mr), .i_issue_rd(rd),
    .i_src_addr(src), .i_src_used(used), .o_fwd_sel(sel2), .o_stall(st2)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(cyc2)
`endif
  );

  hazard_scoreboard #(.FWD_STAGES(3), .LOAD_LAT(2)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_hold(hold), .i_flush(flush),
    .i_issue_regwrite(rw), .i_issue_memread(mr), .i_issue_rd(rd),
    .i_src_addr(src), .i_src_used(used), .o_fwd_sel(sel3), .o_stall(st3)
`ifdef HAZARD_PERF_CNT_EN
    , .o_stall_cycles(cyc3)
`endif
  );

  typedef struct {
    bit       v;
    bit       m;
    bit [4:0] rd;
  } ent_t;

  // Index 0 is the youngest in-flight instruction; list length = forwarding depth.
  ent_t q2[$];
  ent_t q3[$];

  logic [3:0] e_sel2, e_sel3, o_sel2, o_sel3;
  logic       e_st2, e_st3, o_st2, o_st3;

  function automatic void predict(input ent_t q[$], input int alat, input int llat,
                                  input logic [9:0] a, input logic [1:0] u,
                                  output logic [3:0] sel, output logic stall);
    sel   = '0;
    stall = 1'b0;
    for (int j = 0; j < 2; j++) begin
      logic [4:0] s;
      s = a[j*5 +: 5];
      if (u[j] && s != 5'd0) begin
        for (int k = 0; k < q.size(); k++) begin
          if (q[k].v && q[k].rd == s) begin
            if (k >= (q[k].m ? llat : alat)) sel[j*2 +: 2] = 2'(k + 1);
            else stall = 1'b1;
            break;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic advance(inout ent_t q[$], input logic stall_pred);
    ent_t e;
    if (rst) begin
      foreach (q[k]) q[k].v = 1'b0;
    end else if (!hold) begin
      e.v  = rw && !stall_pred && !flush;
      e.m  = mr;
      e.rd = rd;
      q.push_front(e);
      void'(q.pop_back());
    end
  endtask

  task automatic step(input bit en, input logic r, input logic h, input logic f,
                      input logic w, input logic m, input logic [4:0] d,
                      input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] u);
    rst = r; hold = h; flush = f; rw = w; mr = m; rd = d;
    src = {a1, a0}; used = u;
    #1;
    predict(q2, 0, 1, src, used, e_sel2, e_st2);
    predict(q3, 0, 2, src, used, e_sel3, e_st3);
    o_sel2 = sel2; o_st2 = st2; o_sel3 = sel3; o_st3 = st3;
    if (en) begin
      chk("sel_d2", 32'(sel2), 32'(e_sel2));
      chk("stall_d2", 32'(st2), 32'(e_st2));
      chk("sel_d3", 32'(sel3), 32'(e_sel3));
      chk("stall_d3", 32'(st3), 32'(e_st3));
`ifdef HAZARD_PERF_CNT_EN
      chk("cnt_d2", cyc2, cnt2);
      chk("cnt_d3", cyc3, cnt3);
`endif
    end
    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    if (r) begin cnt2 = 0; cnt3 = 0; end
    else if (!h) begin
      if (e_st2) cnt2++;
      if (e_st3) cnt3++;
    end
`endif
    advance(q2, e_st2);
    advance(q3, e_st3);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00);
  endtask

  initial begin
    ent_t z;
    z.v = 1'b0; z.m = 1'b0; z.rd = '0;
    repeat (2) q2.push_back(z);
    repeat (3) q3.push_back(z);
    @(posedge clk); #1;

    // Reset for 2 cycles, then sources that would match stale garbage must see nothing
    step(0, 1, 0, 0, 1, 1, 5'd8, 5'd8, 5'd8, 2'b11);
    step(1, 1, 0, 0, 0, 0, 5'd0, 5'd8, 5'd9, 2'b11);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd8, 5'd9, 2'b11);
    chk("reset_sel", 32'(o_sel2), 32'd0);
    chk("reset_stall", 32'(o_st2), 32'd0);

    // ALU chain: EX forward then MEM forward
    step(1, 0, 0, 0, 1, 0, 5'd8, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 2'b01);
    chk("alu_ex_sel0", 32'(o_sel2[1:0]), 32'd1);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd8, 5'd0, 2'b01);
    chk("alu_mem_sel0", 32'(o_sel2[1:0]), 32'd2);
    idle(3);

    // Load-use on rt: one stall on the default unit, two on the deeper one
    step(1, 0, 0, 0, 1, 1, 5'd9, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9, 2'b10);
    chk("ld_stall_d2", 32'(o_st2), 32'd1);
    chk("ld_stall1_d3", 32'(o_st3), 32'd1);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9, 2'b10);
    chk("ld_fwd_d2", 32'(o_sel2[3:2]), 32'd2);
    chk("ld_stall2_d3", 32'(o_st3), 32'd1);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9, 2'b10);
    chk("ld_fwd_d3", 32'(o_sel3[3:2]), 32'd3);
    chk("ld_done_stall_d3", 32'(o_st3), 32'd0);
    idle(3);

    // Youngest writer wins
    step(1, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01);
    chk("young_sel", 32'(o_sel2[1:0]), 32'd1);
    idle(3);
    step(1, 0, 0, 0, 1, 1, 5'd5, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01);
    chk("young_alu_over_ld_sel", 32'(o_sel2[1:0]), 32'd1);
    chk("young_alu_over_ld_stall", 32'(o_st2), 32'd0);
    idle(3);

    // Register 0 and unused operand
    step(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b11);
    chk("r0_sel", 32'(o_sel2), 32'd0);
    step(1, 0, 0, 0, 1, 1, 5'd7, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd7, 5'd7, 2'b00);
    chk("unused_stall", 32'(o_st2), 32'd0);
    idle(3);

    // Hold freezes a pending load-use; exactly one stall after release
    step(1, 0, 0, 0, 1, 1, 5'd9, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd9, 2'b10);
      chk("hold_stall", 32'(o_st2), 32'd1);
    end
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9, 2'b10);
    chk("post_hold_stall", 32'(o_st2), 32'd1);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd9, 2'b10);
    chk("post_hold_fwd", 32'(o_sel2), 32'h8);
    idle(3);

    // Flush kills the issuing writer
    step(1, 0, 0, 1, 1, 0, 5'd12, 5'd0, 5'd0, 2'b00);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd12, 5'd12, 2'b11);
    chk("flush_sel", 32'(o_sel2), 32'd0);

    // Randomized traffic on a small register window to force collisions
    for (int i = 0; i < 400; i++) begin
      step(1, ($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(7) == 0),
           1'($urandom), 1'($urandom), 5'($urandom_range(7)),
           5'($urandom_range(7)), 5'($urandom_range(7)), 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
